// File: rtl/raquette_pkg.sv
// raquette_pkg: shared definitions for the paddle position controller.
//   dir_t       : motion encoding driven on the dir output
//                 (00 idle, 01 left, 10 right)
//   SCREEN_W,
//   PAD_W,
//   POS_W       : default playfield geometry
//   center_pos(): left-edge X that centres the paddle in the playfield
package raquette_pkg;

  localparam int SCREEN_W = 640;
  localparam int PAD_W    = 80;
  localparam int POS_W    = 11;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_t;

  function automatic int center_pos(input int screen_w, input int pad_w);
    return (screen_w - pad_w) / 2;
  endfunction

endpackage

// File: rtl/raquette_pos_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a debounce counter for one
// active-low push-button.
//   clk, reset_n : system clock, asynchronous active-low reset
//   btn_n        : raw button level, asynchronous, active-low
//   pressed      : debounced press, active-high
// The debounced level only flips after the synchronized input has
// disagreed with it for DEBOUNCE_CYC consecutive cycles; any cycle of
// agreement restarts the count.
module btn_debounce
  import raquette_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             state_n_reg;  // debounced level, active-low like the input
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      state_n_reg <= 1'b1;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == state_n_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // this is the DEBOUNCE_CYC-th consecutive cycle of disagreement
        state_n_reg <= sync2_reg;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pressed = ~state_n_reg;

endmodule

// File: rtl/raquette_pos_ctrl.sv
// raquette_pos_ctrl: paddle position controller for the brick-breaker game.
//   clk, reset_n     : 50 MHz clock, asynchronous active-low reset
//   btn_left_n,
//   btn_right_n      : raw KEY inputs, asynchronous, active-low
//   frame_tick       : one-cycle pulse per video frame
//   center           : one-cycle recenter request (wins over frame_tick)
//   pos_raquette     : registered paddle left-edge X, clamped to
//                      [0, SCREEN_W-PAD_W]
//   dir              : registered motion state (00 idle, 01 left, 10 right)
// Optional feature macro: RAQUETTE_ACCEL_EN -- when defined the step grows
// by one pixel every RAMP_FRAMES moving frames, up to SPEED_MAX; when
// undefined the step is fixed at SPEED_MIN.
module raquette_pos_ctrl #(
  parameter int SCREEN_W     = raquette_pkg::SCREEN_W,
  parameter int PAD_W        = raquette_pkg::PAD_W,
  parameter int POS_W        = raquette_pkg::POS_W,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SPEED_MIN    = 2,
  parameter int SPEED_MAX    = 8,
  parameter int RAMP_FRAMES  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             frame_tick,
  input  logic             center,
  output logic [POS_W-1:0] pos_raquette,
  output logic [1:0]       dir
);

  import raquette_pkg::*;

  if (RAMP_FRAMES < 1 || SPEED_MAX < SPEED_MIN) begin : g_bad_cfg
    $error("raquette_pos_ctrl: RAMP_FRAMES must be >= 1 and SPEED_MAX >= SPEED_MIN");
  end

  localparam logic [POS_W-1:0] CENTER_POS = POS_W'(center_pos(SCREEN_W, PAD_W));
  localparam logic [POS_W-1:0] MAX_POS    = POS_W'(SCREEN_W - PAD_W);
  localparam logic [POS_W-1:0] SPEED_LO   = POS_W'(SPEED_MIN);

  // ---------------------------------------------------------------- buttons
  logic left_pressed;
  logic right_pressed;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_left_n),
    .pressed (left_pressed)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_right_n),
    .pressed (right_pressed)
  );

  // ---------------------------------------------------------------- FSM
  dir_t state_reg;
  dir_t state_next;
  logic state_change;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= DIR_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = DIR_IDLE;
    if (left_pressed && !right_pressed)      state_next = DIR_LEFT;
    else if (right_pressed && !left_pressed) state_next = DIR_RIGHT;
  end

  assign state_change = (state_next != state_reg);
  assign dir          = state_reg;

  // ---------------------------------------------------------------- speed
  logic [POS_W-1:0] speed;

`ifdef RAQUETTE_ACCEL_EN
  localparam int RAMP_W = (RAMP_FRAMES < 2) ? 1 : $clog2(RAMP_FRAMES);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [POS_W-1:0]  SPEED_HI  = POS_W'(SPEED_MAX);

  logic [POS_W-1:0]  speed_reg;
  logic [RAMP_W-1:0] frame_cnt_reg;

  // The move in a tick cycle reads speed_reg before this block updates it,
  // so a ramp step or a state-change reset only affects later frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_reg     <= SPEED_LO;
      frame_cnt_reg <= '0;
    end else if (center || state_change) begin
      speed_reg     <= SPEED_LO;
      frame_cnt_reg <= '0;
    end else if (frame_tick && state_reg != DIR_IDLE) begin
      if (frame_cnt_reg == RAMP_LAST) begin
        frame_cnt_reg <= '0;
        if (speed_reg < SPEED_HI) speed_reg <= speed_reg + 1'b1;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign speed = speed_reg;
`else
  assign speed = SPEED_LO;
`endif

  // ---------------------------------------------------------------- position
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic [POS_W:0]   pos_sum;  // one spare bit so the right-move sum cannot wrap

  assign pos_sum = {1'b0, pos_reg} + {1'b0, speed};

  always_comb begin
    pos_next = pos_reg;
    if (center) begin
      pos_next = CENTER_POS;
    end else if (frame_tick) begin
      case (state_reg)
        DIR_LEFT:  pos_next = (pos_reg >= speed) ? (pos_reg - speed) : '0;
        DIR_RIGHT: pos_next = (pos_sum > {1'b0, MAX_POS}) ? MAX_POS
                                                          : pos_sum[POS_W-1:0];
        default:   pos_next = pos_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pos_reg <= CENTER_POS;
    else          pos_reg <= pos_next;
  end

  assign pos_raquette = pos_reg;

endmodule

// File: tb/tb_raquette_pos_ctrl.sv
// Testbench for raquette_pos_ctrl: randomized button/frame/center stimulus
// with a behavioural paddle model. Every frame_tick/center pushes the
// expected (pos, dir) into a queue; a monitor pops and compares one cycle
// later, when the registered outputs have updated.
`timescale 1ns/1ps
module tb_raquette_pos_ctrl;

  localparam int DEB       = 4;
  localparam int CENTER_X  = 280;
  localparam int MAX_X     = 560;
  localparam int SPEED_MIN = 2;
  localparam int SPEED_MAX = 8;
  localparam int RAMP      = 4;
`ifdef RAQUETTE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_left_n = 1'b1;
  logic        btn_right_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        center = 1'b0;
  logic [10:0] pos_raquette;
  logic [1:0]  dir;

  always #5 clk = ~clk;

  raquette_pos_ctrl #(.DEBOUNCE_CYC(DEB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_left_n   (btn_left_n),
    .btn_right_n  (btn_right_n),
    .frame_tick   (frame_tick),
    .center       (center),
    .pos_raquette (pos_raquette),
    .dir          (dir)
  );

  typedef struct {
    int pos;
    int dir;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_txn  = 0;
  logic chk_pending = 1'b0;

  // behavioural model: paddle position, step, frames since last step change,
  // and the motion the held buttons call for
  int m_pos, m_speed, m_fcnt, m_dir;
  bit m_left, m_right;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int want_dir(input bit l, input bit r);
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_pos   = CENTER_X;
    m_speed = SPEED_MIN;
    m_fcnt  = 0;
    m_dir   = 0;
  endtask

  task automatic model_event(input bit tk, input bit ct);
    exp_t e;
    if (ct) begin
      m_pos   = CENTER_X;
      m_speed = SPEED_MIN;
      m_fcnt  = 0;
    end else if (tk) begin
      if (m_dir == 1) m_pos = (m_pos >= m_speed) ? m_pos - m_speed : 0;
      else if (m_dir == 2) m_pos = (m_pos + m_speed > MAX_X) ? MAX_X : m_pos + m_speed;
      if (ACCEL && m_dir != 0) begin
        m_fcnt++;
        if (m_fcnt == RAMP) begin
          m_fcnt  = 0;
          m_speed = (m_speed + 1 > SPEED_MAX) ? SPEED_MAX : m_speed + 1;
        end
      end
    end
    e.pos = m_pos;
    e.dir = m_dir;
    exp_q.push_back(e);
  endtask

  // monitor: the outputs settle one edge after a tick/center cycle
  always @(posedge clk) chk_pending <= frame_tick | center;

  always @(negedge clk) begin
    if (chk_pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output update with no expectation queued (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: pos=%0d dir=%0d expected pos=%0d dir=%0d",
                 n_txn, pos_raquette, dir, e.pos, e.dir);
        check("pos", int'(pos_raquette), e.pos);
        check("dir", int'(dir), e.dir);
      end
    end
  end

  task automatic drive_cycle(input bit tk, input bit ct);
    @(negedge clk);
    frame_tick = tk;
    center     = ct;
    if (tk || ct) model_event(tk, ct);
  endtask

  // n frames of 10 cycles, tick on the first; optional random center pulses
  task automatic run_frames(input int n, input int center_pct);
    for (int f = 0; f < n; f++) begin
      bit do_c;
      int c_at;
      do_c = ($urandom_range(99) < center_pct);
      c_at = $urandom_range(9);
      for (int c = 0; c < 10; c++)
        drive_cycle(c == 0, do_c && (c == c_at));
    end
    drive_cycle(0, 0);
  endtask

  // change buttons with ticks paused and check the exact press-to-dir latency
  task automatic set_buttons(input bit l, input bit r);
    int old_dir, new_dir;
    old_dir = m_dir;
    new_dir = want_dir(l, r);
    @(negedge clk);
    frame_tick  = 1'b0;
    center      = 1'b0;
    btn_left_n  = ~l;
    btn_right_n = ~r;
    m_left      = l;
    m_right     = r;
    repeat (2 + DEB) @(negedge clk);
    check("dir_before_latency", int'(dir), old_dir);
    @(negedge clk);
    check("dir_after_latency", int'(dir), new_dir);
    if (new_dir != m_dir) begin
      m_speed = SPEED_MIN;
      m_fcnt  = 0;
    end
    m_dir = new_dir;
    repeat (3) @(negedge clk);
    check("pos_hold_on_button", int'(pos_raquette), m_pos);
  endtask

  // left button low for 3 cycles only: shorter than the debounce window
  task automatic left_glitch();
    if (m_left) return;
    @(negedge clk);
    btn_left_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_left_n = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_dir", int'(dir), m_dir);
    check("glitch_pos", int'(pos_raquette), m_pos);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_left  = 1'b0;
    m_right = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_pos", int'(pos_raquette), CENTER_X);
    check("reset_dir", int'(dir), 0);

    // idle hold over 20 frames
    run_frames(20, 0);

    // right until saturation at 560
    set_buttons(1'b0, 1'b1);
    run_frames(150, 0);
    check("right_saturated", int'(pos_raquette), MAX_X);

    // left down to the 0 clamp and staying there
    set_buttons(1'b1, 1'b0);
    run_frames(300, 0);
    check("left_clamped", int'(pos_raquette), 0);

    // center coinciding with a frame tick while moving right past 500
    set_buttons(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    set_buttons(1'b0, 1'b1);
    for (int i = 0; i < 200 && m_pos < 500; i++) run_frames(1, 0);
    drive_cycle(1'b1, 1'b1);
    for (int c = 1; c < 10; c++) drive_cycle(0, 0);
    run_frames(2, 0);

    // glitch and both-pressed
    set_buttons(1'b0, 1'b0);
    left_glitch();
    set_buttons(1'b1, 1'b1);
    run_frames(5, 0);

    // asynchronous reset while the left button is mid-debounce
    set_buttons(1'b0, 1'b1);
    run_frames(3, 0);
    drive_cycle(0, 0);
    drive_cycle(0, 0);
    btn_left_n  = 1'b0;
    btn_right_n = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_pos", int'(pos_raquette), CENTER_X);
    check("async_reset_dir", int'(dir), 0);
    btn_left_n = 1'b1;
    m_left     = 1'b0;
    m_right    = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_dir", int'(dir), 0);
    check("post_reset_pos", int'(pos_raquette), CENTER_X);

    // randomized phases
    for (int p = 0; p < 16; p++) begin
      int sel;
      sel = $urandom_range(3);
      set_buttons(sel[0], sel[1]);
      if ($urandom_range(3) == 0) left_glitch();
      run_frames($urandom_range(40, 1), 12);
    end

    repeat (3) drive_cycle(0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
